spi_mstr_gen: RTL and testbench

Parametrised SPI master for the logic-analyzer test environment. It generates SS_n, SCLK and MOSI stimulus for SPI protocol triggering on CH1–CH3. It supersedes the fixed 8/16-bit, falling-edge-only master with four features:
- runtime word length (1..DATA_W);
- all four CPOL/CPHA modes;
- MSB- or LSB-first bit order;
- a MISO capture path, so a loopback bench can self-check.

---
 rtl/spi_mstr_gen_if.sv | 31 +++
 rtl/spi_mstr_gen.sv | 171 +++++++++++++++++
 tb/tb_spi_mstr_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mstr_gen_if.sv
// Signal bundle between the SPI stimulus master and whatever drives or observes it.
// The master modport is the DUT side; the slave modport is the controlling or observing side.
interface spi_mstr_gen_if #(
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned LenW = $clog2(DATA_W + 1);

  logic              wrt;
  logic [DATA_W-1:0] data_out;
  logic [LenW-1:0]   len;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic              MISO;
  logic              SS_n;
  logic              SCLK;
  logic              MOSI;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_in;

  modport master (
    input  wrt, data_out, len, cpol, cpha, lsb_first, MISO,
    output SS_n, SCLK, MOSI, busy, done, data_in
  );

  modport slave (
    output wrt, data_out, len, cpol, cpha, lsb_first, MISO,
    input  SS_n, SCLK, MOSI, busy, done, data_in
  );
endinterface

// File: rtl/spi_mstr_gen.sv
// Parametrised SPI master: runtime word length, all CPOL/CPHA modes, MSB/LSB-first order,
// and a MISO capture path. Settings are latched when wrt is accepted.
module spi_mstr_gen #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mstr_gen_if.master spi_io
);

  localparam int unsigned H    = SCLK_DIV / 2;
  localparam int unsigned HW   = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned LenW = $clog2(DATA_W + 1);
  localparam int unsigned KW   = $clog2(2 * DATA_W + 1);
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if ((SCLK_DIV % 2) != 0 || SCLK_DIV < 4) begin : g_bad_div
    $error("spi_mstr_gen: SCLK_DIV must be even and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StShift, StBack} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LenW-1:0]   n_q, n_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LenW-1:0] len_clamped;
  logic [IdxW-1:0] first_idx;
  logic [KW-1:0]   k_next;
  logic [IdxW-1:0] tx_pos, rx_pos, tx_idx, rx_idx;
  logic            half_tick, sample_edge, drive_edge, last_edge;

  always_comb begin
    len_clamped = spi_io.len;
    if (spi_io.len == '0 || spi_io.len > LenW'(DATA_W)) begin
      len_clamped = LenW'(DATA_W);
    end
    first_idx = spi_io.lsb_first ? '0 : IdxW'(len_clamped - LenW'(1));
  end

  // Bit position in time order for the edge about to happen; with cpha=1 the sample
  // edge is the trailing one, so it refers to the bit driven one toggle earlier.
  always_comb begin
    k_next      = k_q + KW'(1);
    half_tick   = (hcnt_q == HW'(H - 1));
    last_edge   = (k_next == KW'({n_q, 1'b0}));
    sample_edge = k_next[0] ^ cpha_q;
    drive_edge  = ~sample_edge & ~last_edge;
    tx_pos      = IdxW'(k_next >> 1);
    rx_pos      = cpha_q ? IdxW'((k_next >> 1) - KW'(1)) : IdxW'(k_next >> 1);
    tx_idx      = lsb_q ? tx_pos : IdxW'(n_q - LenW'(1)) - tx_pos;
    rx_idx      = lsb_q ? rx_pos : IdxW'(n_q - LenW'(1)) - rx_pos;
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    k_d     = k_q;
    n_d     = n_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      StIdle: begin
        sclk_d = spi_io.cpol;
        mosi_d = 1'b1;
        ss_n_d = 1'b1;
        if (spi_io.wrt) begin
          state_d = StShift;
          n_d     = len_clamped;
          tx_d    = spi_io.data_out;
          cpol_d  = spi_io.cpol;
          cpha_d  = spi_io.cpha;
          lsb_d   = spi_io.lsb_first;
          hcnt_d  = '0;
          k_d     = '0;
          rx_d    = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = spi_io.cpha ? 1'b1 : spi_io.data_out[first_idx];
        end
      end
      StShift: begin
        hcnt_d = hcnt_q + HW'(1);
        if (half_tick) begin
          hcnt_d = '0;
          k_d    = k_next;
          sclk_d = ~sclk_q;
          if (sample_edge) rx_d[rx_idx] = spi_io.MISO;
          if (drive_edge) mosi_d = tx_q[tx_idx];
          if (last_edge) state_d = StBack;
        end
      end
      StBack: begin
        hcnt_d = hcnt_q + HW'(1);
        if (half_tick) begin
          hcnt_d  = '0;
          state_d = StIdle;
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      k_q     <= k_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign spi_io.SS_n    = ss_n_q;
  assign spi_io.SCLK    = sclk_q;
  assign spi_io.MOSI    = mosi_q;
  assign spi_io.busy    = busy_q;
  assign spi_io.done    = done_q;
  assign spi_io.data_in = rx_q;

endmodule

// File: tb/tb_spi_mstr_gen.sv
// Self-checking bench for spi_mstr_gen: vector table of transfers plus hand-written
// sequences for reset, ignored wrt and back-to-back starts.
`timescale 1ns/1ps
module tb_spi_mstr_gen;
  localparam int unsigned DataW   = 16;
  localparam int unsigned SclkDiv = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mstr_gen_if #(.DATA_W(DataW)) bus ();

  spi_mstr_gen #(.DATA_W(DataW), .SCLK_DIV(SclkDiv)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi_io(bus)
  );

  // 0: loopback, 1: tied high, 2: follows SCLK (high only just before falling edges)
  logic [1:0] miso_sel = 2'd0;
  assign bus.MISO = (miso_sel == 2'd0) ? bus.MOSI : (miso_sel == 2'd1) ? 1'b1 : bus.SCLK;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic        lsb;
    logic [4:0]  len;
    logic [15:0] data;
    logic [1:0]  miso_sel;
    logic [15:0] exp_data;
    int unsigned exp_low;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int unsigned low;
    logic [31:0] stream;
    int unsigned nbits;
  } sb_t;

  sb_t sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  string cur_name = "reset";

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", cur_name, name, got, exp);
    end
  endtask

  function automatic int unsigned clamp(input logic [4:0] len);
    return (len == 5'd0 || len > 5'd16) ? 16 : int'(len);
  endfunction

  function automatic logic [31:0] stream_of(input logic [15:0] d, input int unsigned n,
                                            input logic lsb);
    logic [31:0] r = '0;
    for (int i = 0; i < int'(n); i++) r = {r[30:0], lsb ? d[i] : d[int'(n) - 1 - i]};
    return r;
  endfunction

  // Monitor: SS_n window length, toggle count, MOSI at each sampling edge, scoreboard pop.
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_done = 1'b0;
  logic        cur_cpol = 1'b0, cur_cpha = 1'b0;
  int unsigned low_cnt = 0, falls = 0, tgl_cnt = 0, cap_cnt = 0;
  logic [31:0] cap = '0;

  always @(negedge clk) begin
    sb_t e;
    if (!bus.SS_n) begin
      if (prev_ss) begin
        low_cnt = 1;
        falls++;
        tgl_cnt = 0;
        cap = '0;
        cap_cnt = 0;
      end else begin
        low_cnt++;
        if (bus.SCLK != prev_sclk) begin
          tgl_cnt++;
          if ((prev_sclk == cur_cpol) != cur_cpha) begin
            cap = {cap[30:0], bus.MOSI};
            cap_cnt++;
          end
        end
      end
    end
    if (bus.done && !prev_done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s/unexpected_done: got done=1, expected no completion", cur_name);
      end else begin
        e = sb_q.pop_front();
        check("data_in", 32'(bus.data_in), 32'(e.data));
        check("ss_low_cycles", low_cnt, e.low);
        check("mosi_stream", cap, e.stream);
        check("mosi_bits", cap_cnt, e.nbits);
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    prev_ss   = bus.SS_n;
    prev_sclk = bus.SCLK;
    prev_done = bus.done;
  end

  task automatic start_xfer(input vec_t v, input bit push);
    sb_t e;
    @(posedge clk); #1;
    bus.cpol      = v.cpol;
    bus.cpha      = v.cpha;
    bus.lsb_first = v.lsb;
    bus.len       = v.len;
    bus.data_out  = v.data;
    miso_sel      = v.miso_sel;
    cur_cpol      = v.cpol;
    cur_cpha      = v.cpha;
    repeat (3) @(posedge clk);
    #1;
    check("sclk_idle", 32'(bus.SCLK), 32'(v.cpol));
    if (push) begin
      e.data   = v.exp_data;
      e.low    = v.exp_low;
      e.nbits  = clamp(v.len);
      e.stream = stream_of(v.data, e.nbits, v.lsb);
      sb_q.push_back(e);
    end
    bus.wrt = 1'b1;
    @(posedge clk); #1;
    bus.wrt = 1'b0;
    check("start_ss_busy_done", {29'd0, bus.SS_n, bus.busy, bus.done}, 32'b010);
  endtask

  task automatic wait_done();
    int unsigned i = 0;
    while (!bus.done && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/done_timeout: got done=0 after %0d cycles, expected done=1", cur_name, i);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int unsigned f0;
    int unsigned i;
    sb_t e;

    bus.wrt = 1'b0; bus.data_out = '0; bus.len = '0;
    bus.cpol = 1'b1; bus.cpha = 1'b0; bus.lsb_first = 1'b0;

    // Reset state, with cpol=1 presented to show SCLK is forced low.
    #23;
    check("rst_outputs", {26'd0, bus.SS_n, bus.SCLK, bus.MOSI, bus.busy, bus.done, 1'b0},
          32'b101000);
    check("rst_data_in", 32'(bus.data_in), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_sclk_follows_cpol", 32'(bus.SCLK), 32'd1);
    bus.cpol = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd8,  16'h0096, 2'd0, 16'h0096, 272};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd16, 16'hA5C3, 2'd0, 16'hA5C3, 528};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd4,  16'h0005, 2'd1, 16'h000F, 144};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd4,  16'h0003, 2'd2, 16'h000F, 144};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd5,  16'h0013, 2'd0, 16'h0013, 176};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd1,  16'h0001, 2'd0, 16'h0001, 48};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 5'd20, 16'hBEEF, 2'd0, 16'hBEEF, 528};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 5'd3,  16'hFFFE, 2'd0, 16'h0006, 112};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 5'd8,  16'h0000, 2'd1, 16'h00FF, 272};

    for (int k = 0; k < 9; k++) begin
      cur_name = $sformatf("vec%0d", k);
      start_xfer(vecs[k], 1'b1);
      wait_done();
    end

    // Reset while idle with done set and data_in non-zero.
    cur_name = "rst_idle";
    #3 rst_n = 1'b0;
    #1;
    check("done_cleared", 32'(bus.done), 32'd0);
    check("data_in_cleared", 32'(bus.data_in), 32'd0);
    check("sclk_low", 32'(bus.SCLK), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // len=0 means full width; a wrt mid-transfer must not start a second window.
    cur_name = "len0_wrt_ignored";
    v = '{1'b0, 1'b0, 1'b0, 5'd0, 16'h1234, 2'd0, 16'h1234, 528};
    f0 = falls;
    start_xfer(v, 1'b1);
    i = 0;
    while (tgl_cnt < 7 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    bus.data_out = 16'hFFFF;
    bus.len      = 5'd4;
    bus.cpol     = 1'b1;
    bus.wrt      = 1'b1;
    @(posedge clk); #1;
    bus.wrt  = 1'b0;
    bus.cpol = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("one_window", falls - f0, 32'd1);
    check("idle_after", {30'd0, bus.SS_n, bus.busy}, 32'b10);

    // Back-to-back: wrt presented as done rises is taken on the next (first idle) cycle.
    cur_name = "back_to_back";
    v = '{1'b0, 1'b0, 1'b0, 5'd1, 16'h0001, 2'd0, 16'h0001, 48};
    start_xfer(v, 1'b1);
    i = 0;
    while (!bus.done && i < 2000) begin
      @(negedge clk);
      i++;
    end
    e.data = 16'h0000; e.low = 48; e.nbits = 1; e.stream = 32'd0;
    sb_q.push_back(e);
    bus.data_out = 16'h0000;
    bus.wrt = 1'b1;
    @(posedge clk); #1;
    bus.wrt = 1'b0;
    check("b2b_accept", {29'd0, bus.SS_n, bus.busy, bus.done}, 32'b010);
    wait_done();

    // Reset at toggle 5 of a len=8 transfer, then a clean transfer.
    cur_name = "rst_mid_xfer";
    v = '{1'b0, 1'b0, 1'b0, 5'd8, 16'h00FF, 2'd0, 16'h00FF, 272};
    start_xfer(v, 1'b0);
    i = 0;
    while (tgl_cnt < 5 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {27'd0, bus.SS_n, bus.SCLK, bus.MOSI, bus.busy, bus.done}, 32'b10100);
    check("abort_data_in", 32'(bus.data_in), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cur_name = "after_abort";
    v = '{1'b0, 1'b0, 1'b0, 5'd8, 16'h005A, 2'd0, 16'h005A, 272};
    start_xfer(v, 1'b1);
    wait_done();
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
